// File: rtl/key_debouncer.sv
// N-key synchroniser + per-key stability-counter debouncer with press/release strobes.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from first sampling edge; no backpressure.
module key_debouncer #(
   parameter int N_KEYS          = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] pressed,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic              button_down,
   output logic              any_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] w_norm;
   logic [N_KEYS-1:0] w_sync;
   logic [N_KEYS-1:0] r_sync [SYNC_STAGES];
   logic [CW-1:0]     r_cnt  [N_KEYS];
   logic [N_KEYS-1:0] r_pressed;
   logic [N_KEYS-1:0] r_press;
   logic [N_KEYS-1:0] r_release;

   assign w_norm = (ACTIVE_LOW != 0) ? ~key : key;
   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         for (int i = 0; i < N_KEYS; i++) r_cnt[i] <= '0;
         r_pressed <= '0;
         r_press   <= '0;
         r_release <= '0;
      end else begin
         r_sync[0] <= w_norm;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         for (int i = 0; i < N_KEYS; i++) begin
            r_press[i]   <= 1'b0;
            r_release[i] <= 1'b0;
            // Any cycle agreeing with the accepted level restarts qualification.
            if (w_sync[i] == r_pressed[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_pressed[i] <= w_sync[i];
               r_cnt[i]     <= '0;
               r_press[i]   <= w_sync[i];
               r_release[i] <= ~w_sync[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign pressed       = r_pressed;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign button_down   = |r_pressed;
   assign any_press     = |r_press;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboarded bench: expected strobes queued at stimulus time, popped when a strobe appears.
module tb_key_debouncer;
   localparam int LAT = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key;
   logic [1:0] pressed, press_pulse, release_pulse;
   logic       button_down, any_press;

   typedef struct {
      int         at;
      logic [1:0] prs;
      logic [1:0] pp;
      logic [1:0] rp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_err = 0;

   key_debouncer #(
      .N_KEYS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .key(key),
      .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .button_down(button_down), .any_press(any_press)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_strobe(input int at, input logic [1:0] prs,
                                input logic [1:0] pp, input logic [1:0] rp);
      sb.push_back('{at, prs, pp, rp});
   endtask

   always @(negedge clk) begin
      if ((press_pulse | release_pulse) != 2'b00) begin
         check("pulse_excl", int'(press_pulse & release_pulse), 0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", int'({press_pulse, release_pulse}), 0);
         end else begin
            mon_e = sb.pop_front();
            check("strobe_cycle", cyc, mon_e.at);
            check("pressed", int'(pressed), int'(mon_e.prs));
            check("press_pulse", int'(press_pulse), int'(mon_e.pp));
            check("release_pulse", int'(release_pulse), int'(mon_e.rp));
            check("any_press", int'(any_press), int'(|mon_e.pp));
            check("button_down", int'(button_down), int'(|mon_e.prs));
         end
      end else if (sb.size() > 0 && cyc > sb[0].at) begin
         check("missed_strobe", cyc, sb[0].at);
         sb.delete(0);
      end
   end

   initial begin
      reset = 1'b1;
      key   = 2'b00;
      tick(3);
      check("rst_pressed", int'(pressed), 0);
      check("rst_button_down", int'(button_down), 0);
      check("rst_any_press", int'(any_press), 0);

      // Both keys held through reset: accepted as a press after full latency.
      reset = 1'b0;
      expect_strobe(cyc + LAT, 2'b11, 2'b11, 2'b00);
      tick(10);

      // Release both, then press key 0 alone.
      key = 2'b11;
      expect_strobe(cyc + LAT, 2'b00, 2'b00, 2'b11);
      tick(10);
      key = 2'b10;
      expect_strobe(cyc + LAT, 2'b01, 2'b01, 2'b00);
      tick(5);
      check("pre_latency_pressed", int'(pressed), 0);
      tick(1);
      check("k0_pressed", int'(pressed), 1);
      check("k0_button_down", int'(button_down), 1);
      tick(4);

      // Release key 0, then a bounce burst settling low.
      key = 2'b11;
      expect_strobe(cyc + LAT, 2'b00, 2'b00, 2'b01);
      tick(10);
      key[0] = 1'b0; tick(1);
      key[0] = 1'b1; tick(1);
      key[0] = 1'b0; tick(1);
      key[0] = 1'b1; tick(1);
      key[0] = 1'b0;
      expect_strobe(cyc + LAT, 2'b01, 2'b01, 2'b00);
      tick(10);

      // Short glitch on key 1 is filtered out.
      key[1] = 1'b0; tick(3);
      key[1] = 1'b1; tick(10);
      check("glitch_pressed", int'(pressed), 1);

      // Both held, then key 0 released; button_down must never drop.
      key = 2'b00;
      expect_strobe(cyc + LAT, 2'b11, 2'b10, 2'b00);
      tick(10);
      key = 2'b01;
      expect_strobe(cyc + LAT, 2'b10, 2'b00, 2'b01);
      for (int i = 0; i < 10; i++) begin
         check("bd_hold", int'(button_down), 1);
         tick(1);
      end

      // Reset mid-debounce on key 0 while key 1 is held.
      key = 2'b00;
      tick(4);
      check("cnt_mid", int'(dut.r_cnt[0]), 2);
      reset = 1'b1;
      tick(1);
      check("rst_mid_pressed", int'(pressed), 0);
      check("rst_mid_cnt", int'(dut.r_cnt[0]), 0);
      reset = 1'b0;
      expect_strobe(cyc + LAT, 2'b11, 2'b11, 2'b00);
      tick(10);

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
